// File: rtl/lu_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// lu_arbiter_pkg
// Shared definitions for the logical-unit arbiter slice:
//   - requester ID encoding (REQ0 / REQ1)
//   - truth-table width FUNC_W
//   - named truth tables; out = func[{a,b}]
// ---------------------------------------------------------------------------
package lu_arbiter_pkg;

  localparam int FUNC_W = 4;

  typedef logic req_id_t;

  localparam req_id_t REQ0 = 1'b0;
  localparam req_id_t REQ1 = 1'b1;

  localparam logic [FUNC_W-1:0] FUNC_AND  = 4'b1000;
  localparam logic [FUNC_W-1:0] FUNC_OR   = 4'b1110;
  localparam logic [FUNC_W-1:0] FUNC_XOR  = 4'b0110;
  localparam logic [FUNC_W-1:0] FUNC_NAND = 4'b0111;

endpackage : lu_arbiter_pkg

// File: rtl/lu_arbiter_if.sv
// ---------------------------------------------------------------------------
// lu_arbiter_if
// Bundles the two requester handshakes, the result slot and the completion
// counters of lu_arbiter.
//   slave  modport : the arbiter (drives readys, result, counters)
//   master modport : requesters + result consumer
// Signals:
//   reqN_valid/ready/func/a/b : requester N operation handshake
//   res_valid/ready/data/id   : registered result slot
//   cnt0/cnt1                 : consumed results per requester (wrapping)
// ---------------------------------------------------------------------------
interface lu_arbiter_if #(
  parameter int CNT_W = 8
) ();
  import lu_arbiter_pkg::*;

  logic              req0_valid;
  logic              req0_ready;
  logic [FUNC_W-1:0] req0_func;
  logic              req0_a;
  logic              req0_b;

  logic              req1_valid;
  logic              req1_ready;
  logic [FUNC_W-1:0] req1_func;
  logic              req1_a;
  logic              req1_b;

  logic              res_valid;
  logic              res_ready;
  logic              res_data;
  req_id_t           res_id;

  logic [CNT_W-1:0]  cnt0;
  logic [CNT_W-1:0]  cnt1;

  modport slave (
    input  req0_valid, req0_func, req0_a, req0_b,
    input  req1_valid, req1_func, req1_a, req1_b,
    input  res_ready,
    output req0_ready, req1_ready,
    output res_valid, res_data, res_id,
    output cnt0, cnt1
  );

  modport master (
    output req0_valid, req0_func, req0_a, req0_b,
    output req1_valid, req1_func, req1_a, req1_b,
    output res_ready,
    input  req0_ready, req1_ready,
    input  res_valid, res_data, res_id,
    input  cnt0, cnt1
  );

endinterface : lu_arbiter_if

// File: rtl/lu_arbiter_logicalunit.sv
// ---------------------------------------------------------------------------
// logicalunit
// 2-input programmable logic function: out = func[{a,b}].
// Ports:
//   a, b : operands
//   func : 4-bit truth table
//   out  : selected truth-table bit
// ---------------------------------------------------------------------------
module logicalunit
  import lu_arbiter_pkg::*;
(
  input  logic              a,
  input  logic              b,
  input  logic [FUNC_W-1:0] func,
  output logic              out
);

  assign out = func[{a, b}];

endmodule : logicalunit

// File: rtl/lu_arbiter.sv
// ---------------------------------------------------------------------------
// lu_arbiter
// Shares one logicalunit between two requesters. Round-robin arbitration with
// a bounded burst allowance feeds a single registered result slot that is
// tagged with the issuing requester and honours consumer backpressure.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : lu_arbiter_if.slave (requester handshakes, result slot, counters)
// Parameters:
//   MAX_BURST : max consecutive grants to one requester while both request
//   CNT_W     : width of the per-requester consumed-result counters
// ---------------------------------------------------------------------------
module lu_arbiter
  import lu_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  lu_arbiter_if.slave    bus
);

  localparam logic [3:0] MAX_BURST_C = 4'(MAX_BURST);

  // registered state
  logic              res_valid_q, res_valid_d;
  logic              res_data_q,  res_data_d;
  req_id_t           res_id_q,    res_id_d;
  logic [CNT_W-1:0]  cnt0_q,      cnt0_d;
  logic [CNT_W-1:0]  cnt1_q,      cnt1_d;
  req_id_t           last_grant_q, last_grant_d;
  logic [3:0]        burst_cnt_q,  burst_cnt_d;
  logic              granted_prev_q, granted_prev_d;

  // combinational
  logic              slot_free_s;
  logic              grant_s;
  req_id_t           grant_id_s;
  logic [FUNC_W-1:0] lu_func_s;
  logic              lu_a_s;
  logic              lu_b_s;
  logic              lu_out_s;

  // Grant selection; ready is held low during reset and whenever the slot is
  // occupied and not being drained this cycle.
  always_comb begin
    slot_free_s = !res_valid_q || bus.res_ready;
    grant_s     = 1'b0;
    grant_id_s  = REQ0;
    if (!rst_n || !slot_free_s) begin
      grant_s    = 1'b0;
      grant_id_s = REQ0;
    end else if (bus.req0_valid && bus.req1_valid) begin
      grant_s = 1'b1;
      // The previous owner keeps the grant only while its burst is unexhausted
      // and it was granted in the immediately preceding cycle.
      if (granted_prev_q && (burst_cnt_q < MAX_BURST_C)) begin
        grant_id_s = last_grant_q;
      end else begin
        grant_id_s = ~last_grant_q;
      end
    end else if (bus.req0_valid) begin
      grant_s    = 1'b1;
      grant_id_s = REQ0;
    end else if (bus.req1_valid) begin
      grant_s    = 1'b1;
      grant_id_s = REQ1;
    end else begin
      grant_s    = 1'b0;
      grant_id_s = REQ0;
    end
  end

  assign bus.req0_ready = grant_s && (grant_id_s == REQ0);
  assign bus.req1_ready = grant_s && (grant_id_s == REQ1);

  // Route the granted requester's operands to the shared logical unit.
  always_comb begin
    lu_func_s = bus.req0_func;
    lu_a_s    = bus.req0_a;
    lu_b_s    = bus.req0_b;
    if (grant_id_s == REQ1) begin
      lu_func_s = bus.req1_func;
      lu_a_s    = bus.req1_a;
      lu_b_s    = bus.req1_b;
    end else begin
      lu_func_s = bus.req0_func;
      lu_a_s    = bus.req0_a;
      lu_b_s    = bus.req0_b;
    end
  end

  logicalunit u_lu (
    .a    (lu_a_s),
    .b    (lu_b_s),
    .func (lu_func_s),
    .out  (lu_out_s)
  );

  // Next-state for burst tracking, result slot and counters.
  always_comb begin
    res_valid_d    = res_valid_q;
    res_data_d     = res_data_q;
    res_id_d       = res_id_q;
    cnt0_d         = cnt0_q;
    cnt1_d         = cnt1_q;
    last_grant_d   = last_grant_q;
    burst_cnt_d    = burst_cnt_q;
    granted_prev_d = granted_prev_q;

    if (grant_s) begin
      granted_prev_d = 1'b1;
      if ((grant_id_s == last_grant_q) && granted_prev_q) begin
        // A lone requester may keep going past the limit; the count saturates.
        if (burst_cnt_q < MAX_BURST_C) begin
          burst_cnt_d = burst_cnt_q + 4'd1;
        end else begin
          burst_cnt_d = burst_cnt_q;
        end
      end else begin
        burst_cnt_d  = 4'd1;
        last_grant_d = grant_id_s;
      end
    end else begin
      granted_prev_d = 1'b0;
    end

    // A grant overwrites the slot even when it is being consumed this cycle.
    if (grant_s) begin
      res_valid_d = 1'b1;
      res_data_d  = lu_out_s;
      res_id_d    = grant_id_s;
    end else if (res_valid_q && bus.res_ready) begin
      res_valid_d = 1'b0;
    end else begin
      res_valid_d = res_valid_q;
    end

    if (res_valid_q && bus.res_ready) begin
      if (res_id_q == REQ1) begin
        cnt1_d = cnt1_q + CNT_W'(1'b1);
      end else begin
        cnt0_d = cnt0_q + CNT_W'(1'b1);
      end
    end else begin
      cnt0_d = cnt0_q;
      cnt1_d = cnt1_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_valid_q    <= 1'b0;
      res_data_q     <= 1'b0;
      res_id_q       <= REQ0;
      cnt0_q         <= '0;
      cnt1_q         <= '0;
      last_grant_q   <= REQ1;
      burst_cnt_q    <= 4'd0;
      granted_prev_q <= 1'b0;
    end else begin
      res_valid_q    <= res_valid_d;
      res_data_q     <= res_data_d;
      res_id_q       <= res_id_d;
      cnt0_q         <= cnt0_d;
      cnt1_q         <= cnt1_d;
      last_grant_q   <= last_grant_d;
      burst_cnt_q    <= burst_cnt_d;
      granted_prev_q <= granted_prev_d;
    end
  end

  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_id    = res_id_q;
  assign bus.cnt0      = cnt0_q;
  assign bus.cnt1      = cnt1_q;

endmodule : lu_arbiter

// File: tb/tb_lu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_lu_arbiter
// Directed self-checking bench for lu_arbiter. A second instance with a
// 2-bit counter width exercises counter wrap-around.
// ---------------------------------------------------------------------------
module tb_lu_arbiter;
  import lu_arbiter_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  lu_arbiter_if #(.CNT_W(8)) bus  ();
  lu_arbiter_if #(.CNT_W(2)) bus2 ();

  lu_arbiter #(.MAX_BURST(4), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  lu_arbiter #(.MAX_BURST(4), .CNT_W(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  task tick;
    @(posedge clk);
    #1;
  endtask

  task clear_inputs;
    bus.req0_valid = 1'b0; bus.req0_func = 4'b0000; bus.req0_a = 1'b0; bus.req0_b = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_func = 4'b0000; bus.req1_a = 1'b0; bus.req1_b = 1'b0;
    bus.res_ready  = 1'b0;
    bus2.req0_valid = 1'b0; bus2.req0_func = 4'b0000; bus2.req0_a = 1'b0; bus2.req0_b = 1'b0;
    bus2.req1_valid = 1'b0; bus2.req1_func = 4'b0000; bus2.req1_a = 1'b0; bus2.req1_b = 1'b0;
    bus2.res_ready  = 1'b0;
  endtask

  task do_reset;
    clear_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task test_reset;
    clear_inputs();
    bus.req0_valid = 1'b1; bus.req0_func = FUNC_OR;  bus.req0_a = 1'b0; bus.req0_b = 1'b1;
    bus.req1_valid = 1'b1; bus.req1_func = FUNC_AND; bus.req1_a = 1'b0; bus.req1_b = 1'b0;
    bus.res_ready  = 1'b1;
    rst_n = 1'b0;
    tick();
    tick();
    total_cnt++; if (bus.res_valid !== 1'b0) $display("FAIL reset_res_valid got=%0b exp=0", bus.res_valid); else pass_cnt++;
    total_cnt++; if (bus.req0_ready !== 1'b0) $display("FAIL reset_ready0 got=%0b exp=0", bus.req0_ready); else pass_cnt++;
    total_cnt++; if (bus.req1_ready !== 1'b0) $display("FAIL reset_ready1 got=%0b exp=0", bus.req1_ready); else pass_cnt++;
    total_cnt++; if (bus.cnt0 !== 8'd0) $display("FAIL reset_cnt0 got=%0d exp=0", bus.cnt0); else pass_cnt++;
    total_cnt++; if (bus.cnt1 !== 8'd0) $display("FAIL reset_cnt1 got=%0d exp=0", bus.cnt1); else pass_cnt++;
    total_cnt++; if ({bus.res_data, bus.res_id} !== 2'b00) $display("FAIL reset_data_id got=%b exp=00", {bus.res_data, bus.res_id}); else pass_cnt++;
    rst_n = 1'b1;
    #1;
    total_cnt++; if (bus.req0_ready !== 1'b1) $display("FAIL first_grant_ready0 got=%0b exp=1", bus.req0_ready); else pass_cnt++;
    total_cnt++; if (bus.req1_ready !== 1'b0) $display("FAIL first_grant_ready1 got=%0b exp=0", bus.req1_ready); else pass_cnt++;
    tick();
    total_cnt++; if (bus.res_valid !== 1'b1) $display("FAIL first_grant_valid got=%0b exp=1", bus.res_valid); else pass_cnt++;
    total_cnt++; if (bus.res_id !== 1'b0) $display("FAIL first_grant_id got=%0b exp=0", bus.res_id); else pass_cnt++;
    total_cnt++; if (bus.res_data !== 1'b1) $display("FAIL first_grant_data got=%0b exp=1", bus.res_data); else pass_cnt++;
  endtask

  task automatic test_single_xor;
    logic [3:0] exp_data = 4'b0110; // bit i = expected for {a,b}=i
    do_reset();
    bus.res_ready  = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req0_func  = FUNC_XOR;
    for (int i = 0; i < 4; i++) begin
      bus.req0_a = i[1];
      bus.req0_b = i[0];
      #1;
      total_cnt++; if (bus.req0_ready !== 1'b1) $display("FAIL xor_ready0[%0d] got=%0b exp=1", i, bus.req0_ready); else pass_cnt++;
      tick();
      total_cnt++; if (bus.res_valid !== 1'b1) $display("FAIL xor_valid[%0d] got=%0b exp=1", i, bus.res_valid); else pass_cnt++;
      total_cnt++; if (bus.res_data !== exp_data[i]) $display("FAIL xor_data[%0d] got=%0b exp=%0b", i, bus.res_data, exp_data[i]); else pass_cnt++;
      total_cnt++; if (bus.res_id !== 1'b0) $display("FAIL xor_id[%0d] got=%0b exp=0", i, bus.res_id); else pass_cnt++;
    end
    bus.req0_valid = 1'b0;
    tick();
    total_cnt++; if (bus.res_valid !== 1'b0) $display("FAIL xor_drain_valid got=%0b exp=0", bus.res_valid); else pass_cnt++;
    total_cnt++; if (bus.cnt0 !== 8'd4) $display("FAIL xor_cnt0 got=%0d exp=4", bus.cnt0); else pass_cnt++;
    total_cnt++; if (bus.cnt1 !== 8'd0) $display("FAIL xor_cnt1 got=%0d exp=0", bus.cnt1); else pass_cnt++;
  endtask

  task automatic test_burst;
    // req0 drops valid only at step 10; expected grantee per step (1 = req1).
    logic [18:0] v0_vec  = 19'b111_1111_1011_1111_1111;
    logic [18:0] exp_vec = 19'b100_0011_1100_1111_0000;
    do_reset();
    bus.res_ready  = 1'b1;
    bus.req0_func  = FUNC_AND;  bus.req0_a = 1'b1; bus.req0_b = 1'b1;
    bus.req1_func  = FUNC_NAND; bus.req1_a = 1'b1; bus.req1_b = 1'b1;
    bus.req1_valid = 1'b1;
    for (int i = 0; i < 19; i++) begin
      bus.req0_valid = v0_vec[i];
      #1;
      total_cnt++; if (bus.req0_ready !== !exp_vec[i]) $display("FAIL burst_ready0[%0d] got=%0b exp=%0b", i, bus.req0_ready, !exp_vec[i]); else pass_cnt++;
      total_cnt++; if (bus.req1_ready !== exp_vec[i]) $display("FAIL burst_ready1[%0d] got=%0b exp=%0b", i, bus.req1_ready, exp_vec[i]); else pass_cnt++;
      tick();
      total_cnt++; if (bus.res_id !== exp_vec[i]) $display("FAIL burst_id[%0d] got=%0b exp=%0b", i, bus.res_id, exp_vec[i]); else pass_cnt++;
      // AND(1,1)=1 for req0, NAND(1,1)=0 for req1
      total_cnt++; if (bus.res_data !== !exp_vec[i]) $display("FAIL burst_data[%0d] got=%0b exp=%0b", i, bus.res_data, !exp_vec[i]); else pass_cnt++;
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    tick();
    total_cnt++; if (bus.cnt0 !== 8'd10) $display("FAIL burst_cnt0 got=%0d exp=10", bus.cnt0); else pass_cnt++;
    total_cnt++; if (bus.cnt1 !== 8'd9) $display("FAIL burst_cnt1 got=%0d exp=9", bus.cnt1); else pass_cnt++;
  endtask

  task automatic test_backpressure;
    do_reset();
    bus.res_ready  = 1'b0;
    bus.req1_valid = 1'b1;
    bus.req1_func  = FUNC_AND; bus.req1_a = 1'b1; bus.req1_b = 1'b1;
    #1;
    total_cnt++; if (bus.req1_ready !== 1'b1) $display("FAIL bp_first_ready1 got=%0b exp=1", bus.req1_ready); else pass_cnt++;
    tick();
    // next operation would produce XOR(1,1)=0 and must not disturb the held slot
    bus.req1_func = FUNC_XOR;
    for (int i = 0; i < 3; i++) begin
      #1;
      total_cnt++; if ({bus.req0_ready, bus.req1_ready} !== 2'b00) $display("FAIL bp_ready[%0d] got=%b exp=00", i, {bus.req0_ready, bus.req1_ready}); else pass_cnt++;
      tick();
      total_cnt++; if ({bus.res_valid, bus.res_data, bus.res_id} !== 3'b111) $display("FAIL bp_hold[%0d] got=%b exp=111", i, {bus.res_valid, bus.res_data, bus.res_id}); else pass_cnt++;
      total_cnt++; if (bus.cnt1 !== 8'd0) $display("FAIL bp_cnt1[%0d] got=%0d exp=0", i, bus.cnt1); else pass_cnt++;
    end
    bus.res_ready = 1'b1;
    #1;
    total_cnt++; if (bus.req1_ready !== 1'b1) $display("FAIL bp_regrant_ready1 got=%0b exp=1", bus.req1_ready); else pass_cnt++;
    tick();
    total_cnt++; if ({bus.res_valid, bus.res_data, bus.res_id} !== 3'b101) $display("FAIL bp_regrant_slot got=%b exp=101", {bus.res_valid, bus.res_data, bus.res_id}); else pass_cnt++;
    total_cnt++; if (bus.cnt1 !== 8'd1) $display("FAIL bp_regrant_cnt1 got=%0d exp=1", bus.cnt1); else pass_cnt++;
    bus.req1_valid = 1'b0;
    tick();
    total_cnt++; if (bus.res_valid !== 1'b0) $display("FAIL bp_drain_valid got=%0b exp=0", bus.res_valid); else pass_cnt++;
    total_cnt++; if (bus.cnt1 !== 8'd2) $display("FAIL bp_drain_cnt1 got=%0d exp=2", bus.cnt1); else pass_cnt++;
    total_cnt++; if (bus.cnt0 !== 8'd0) $display("FAIL bp_cnt0 got=%0d exp=0", bus.cnt0); else pass_cnt++;
  endtask

  task automatic test_counter_wrap;
    logic [1:0] wrap_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    do_reset();
    bus2.res_ready  = 1'b1;
    bus2.req0_valid = 1'b1;
    bus2.req0_func  = FUNC_OR; bus2.req0_a = 1'b1; bus2.req0_b = 1'b0;
    tick();
    total_cnt++; if (bus2.cnt0 !== 2'd0) $display("FAIL wrap_cnt0_start got=%0d exp=0", bus2.cnt0); else pass_cnt++;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) bus2.req0_valid = 1'b0;
      tick();
      total_cnt++; if (bus2.cnt0 !== wrap_exp[k]) $display("FAIL wrap_cnt0[%0d] got=%0d exp=%0d", k, bus2.cnt0, wrap_exp[k]); else pass_cnt++;
    end
    total_cnt++; if (bus2.res_valid !== 1'b0) $display("FAIL wrap_drain_valid got=%0b exp=0", bus2.res_valid); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    do_reset();
    bus.res_ready  = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req0_func  = FUNC_AND; bus.req0_a = 1'b1; bus.req0_b = 1'b1;
    tick();
    tick();
    bus.req0_valid = 1'b0;
    bus.res_ready  = 1'b0;
    #1;
    total_cnt++; if ({bus.res_valid, bus.cnt0} !== {1'b1, 8'd1}) $display("FAIL mid_pending got=%b/%0d exp=1/1", bus.res_valid, bus.cnt0); else pass_cnt++;
    rst_n = 1'b0;
    tick();
    total_cnt++; if (bus.res_valid !== 1'b0) $display("FAIL mid_reset_valid got=%0b exp=0", bus.res_valid); else pass_cnt++;
    total_cnt++; if (bus.cnt0 !== 8'd0) $display("FAIL mid_reset_cnt0 got=%0d exp=0", bus.cnt0); else pass_cnt++;
    rst_n = 1'b1;
    bus.res_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++; if (bus.res_valid !== 1'b0) $display("FAIL mid_no_replay[%0d] got=%0b exp=0", i, bus.res_valid); else pass_cnt++;
      total_cnt++; if (bus.cnt0 !== 8'd0) $display("FAIL mid_cnt0[%0d] got=%0d exp=0", i, bus.cnt0); else pass_cnt++;
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_xor();
    test_burst();
    test_backpressure();
    test_counter_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_lu_arbiter

// File: doc/lu_arbiter.md
Name: lu_arbiter

Overview:
- Shares one 2-input programmable logical unit (4-bit truth-table function, out = func[{a,b}]) between two requesters.
- Each requester presents {func, a, b} on a valid/ready handshake.
- Round-robin arbitration with a bounded burst allowance; one registered result slot with backpressure, tagged with requester ID.
- Sits between the operand-issuing control logic and any consumer of logical-unit results.

Parameters:
- MAX_BURST, 4, maximum consecutive grants to one requester while the other is requesting (legal range 1..15).
- CNT_W, 8, width of per-requester completed-operation counters.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  synchronous reset, active-low.
- req0_valid  input  1  requester 0 operation valid.
- req0_ready  output  1  requester 0 operation accepted this cycle when valid&ready.
- req0_func  input  4  requester 0 truth table.
- req0_a, req0_b  input  1 each  requester 0 operands.
- req1_valid, req1_ready, req1_func, req1_a, req1_b  as requester 0.
- res_valid  output  1  result slot occupied.
- res_ready  input  1  consumer accepts result when res_valid&res_ready.
- res_data  output  1  logical-unit output for the accepted operation.
- res_id  output  1  requester that issued the result.
- cnt0, cnt1  output  CNT_W  completed (consumed) results per requester, wrap-around.

Behaviour:
- Reset (rst_n=0 at a clk edge): res_valid=0, res_data=0, res_id=0, cnt0=cnt1=0, last_grant=1 (so requester 0 wins first), burst_cnt=0. req*_ready is combinational and is 0 during reset.
- Slot free condition: free = !res_valid | res_ready.
- Grant (combinational):
  - only when free; at most one ready high per cycle.
  - Only one valid: that requester is granted.
  - Both valid: grant the requester other than last_grant, unless last_grant's burst_cnt < MAX_BURST and last_grant was also granted in the previous cycle. In that case last_grant keeps the grant (burst continuation).
  - With both valid, the continuing requester can therefore hold at most MAX_BURST consecutive grants.
- On grant g (valid&ready):
  - next cycle res_valid=1, res_data=func_g[{a_g,b_g}], res_id=g. Latency is 1 cycle.
  - If g==last_grant and that requester was granted in the previous cycle: burst_cnt += 1, saturating at MAX_BURST.
  - Otherwise: burst_cnt=1 and last_grant=g.
- A cycle without a grant clears the "granted previous cycle" flag; burst_cnt restarts at the next grant.
- Slot handling:
  - Result consumed (res_valid&res_ready) with no new grant: res_valid -> 0.
  - Consume and grant in the same cycle: the slot is overwritten with the new result, res_valid stays 1. Full throughput is 1 op/cycle.
  - res_valid&!res_ready: both ready=0, and res_data/res_id hold stable.
- Counters: cnt[res_id] increments on each consumed result (res_valid&res_ready), wrapping from 2^CNT_W-1 to 0.
- The requester's operand fields need only be stable in the cycle of acceptance. The valid/ready protocol forbids dropping valid before acceptance, but the block does not check this.
- Reset mid-operation discards any pending result; nothing is replayed.

Decomposition:
- Shared package:
  - requester ID encoding: REQ0=1'b0, REQ1=1'b1.
  - FUNC_W=4.
  - named truth-table constants: FUNC_AND=4'b1000, FUNC_OR=4'b1110, FUNC_XOR=4'b0110, FUNC_NAND=4'b0111.
- Sub-module: instantiate the existing logicalunit datapath (inputs a, b, func[3:0]; output out) on the muxed grant operands.
- The arbiter and result slot live in lu_arbiter itself.

Test Plan:
- Reset/idle: rst_n=0 for 2 cycles with both valids high -> res_valid=0, both ready=0, cnt0=cnt1=0. After release, first grant goes to requester 0.
- Single requester, all combos: req0 func=FUNC_XOR, {a,b}=00,01,10,11 on consecutive cycles, res_ready=1 -> res_data 0,1,1,0 one cycle after each acceptance, res_id=0, cnt0=4.
- Burst limit: both valid continuously with res_ready=1 and MAX_BURST=4 -> grant pattern 0,0,0,0,1,1,1,1,0...
  - Drop req0_valid for one cycle mid-burst -> req1 granted, and req0 restarts at burst_cnt=1.
- Backpressure: res_ready=0 for 3 cycles with req1 valid (FUNC_AND, a=1, b=1) -> res_data=1 and res_id=1 held, both ready=0, no counter change. Raise res_ready -> same-cycle re-grant, and cnt1 increments once.
- Counter wrap: CNT_W=2, 5 consumed req0 results -> cnt0 sequence 1,2,3,0,1.
- Reset mid-operation: res_valid=1 with res_ready=0, assert rst_n=0 for 1 cycle -> res_valid=0, counters 0, and the pending result is never presented.
